// File: rtl/jt51_so_tx.sv
// JT51 serial DAC transmitter: floating-point encoder and
// YM3012-style 32-slot shift-out with sample-hold strobes.
module jt51_so_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        sample_valid,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        so,
  output logic        sh1,
  output logic        sh2,
  output logic        frame_start,
  output logic        drop
);

  logic [4:0]  cnt;
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic        pending;
  logic [31:0] sreg;
  logic        load;
  logic [31:0] new_word;

  // Word: {exp[2:0], man[9:0], 3'b000}, slot 0 in bit 0.
  function automatic logic [15:0] encode(input logic [15:0] lin);
    logic signed [15:0] s;
    logic [2:0]         e;
    logic [9:0]         man;
    s   = $signed(lin) >>> 6;
    e   = 3'd6;
    man = s[9:0];
    for (int i = 5; i >= 0; i--) begin
      s = $signed(lin) >>> i;
      if (s[15:9] == {7{s[9]}}) begin
        e   = 3'(i);
        man = s[9:0];
      end
    end
    return {e + 3'd1, man, 3'b000};
  endfunction

  // cnt is the slot driven on the next clk_en.
  assign load     = clk_en && (cnt == 5'd0);
  assign new_word = {encode(hold_r), encode(hold_l)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 5'd0;
      hold_l      <= 16'd0;
      hold_r      <= 16'd0;
      pending     <= 1'b0;
      sreg        <= 32'd0;
      so          <= 1'b0;
      sh1         <= 1'b0;
      sh2         <= 1'b0;
      frame_start <= 1'b0;
      drop        <= 1'b0;
    end else if (clk_en) begin
      cnt <= cnt + 5'd1;
      if (load) begin
        so   <= new_word[0];
        sreg <= {1'b0, new_word[31:1]};
      end else begin
        so   <= sreg[0];
        sreg <= {1'b0, sreg[31:1]};
      end
      sh1         <= (cnt >= 5'd13) && (cnt <= 5'd15);
      sh2         <= (cnt >= 5'd29);
      frame_start <= (cnt == 5'd0);
      // A pair captured at load time is not lost: it rides the next frame.
      drop        <= sample_valid && pending && !load;
      if (sample_valid) begin
        hold_l  <= left;
        hold_r  <= right;
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt51_so_tx.sv
// Self-checking bench for jt51_so_tx against a frame-level
// model of the serial stream.
module tb_jt51_so_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] left = 16'd0;
  logic [15:0] right = 16'd0;
  logic        so, sh1, sh2, frame_start, drop;

  int n_checks = 0;
  int n_fail = 0;

  int          m_slot = -1;
  logic [31:0] m_frame = 32'd0;
  logic [15:0] m_hl = 16'd0;
  logic [15:0] m_hr = 16'd0;
  logic        m_pend = 1'b0;
  logic        m_drop = 1'b0;

  jt51_so_tx dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .sample_valid(sample_valid), .left(left), .right(right),
    .so(so), .sh1(sh1), .sh2(sh2),
    .frame_start(frame_start), .drop(drop)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc_word(input logic [15:0] lin);
    int v, q, e, w;
    bit found;
    v = int'($signed(lin));
    found = 0;
    e = 6;
    q = v >>> 6;
    for (int k = 0; k <= 6; k++) begin
      if (!found && (v >>> k) >= -512 && (v >>> k) <= 511) begin
        found = 1;
        e = k;
        q = v >>> k;
      end
    end
    w = ((q & 1023) * 8) + ((e + 1) * 8192);
    return w[15:0];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic ex);
    n_checks++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s slot=%0d: observed %b expected %b",
             tag, m_slot, obs, ex);
    end
  endtask

  task automatic check_outputs();
    logic e_so, e_sh1, e_sh2, e_fs, e_dr;
    if (m_slot < 0) begin
      e_so = 0; e_sh1 = 0; e_sh2 = 0; e_fs = 0; e_dr = 0;
    end else begin
      e_so  = m_frame[m_slot];
      e_sh1 = (m_slot >= 13 && m_slot <= 15);
      e_sh2 = (m_slot >= 29);
      e_fs  = (m_slot == 0);
      e_dr  = m_drop;
    end
    chk("so", so, e_so);
    chk("sh1", sh1, e_sh1);
    chk("sh2", sh2, e_sh2);
    chk("frame_start", frame_start, e_fs);
    chk("drop", drop, e_dr);
  endtask

  task automatic model_step(input logic v, input logic [15:0] l,
                            input logic [15:0] r);
    m_slot = (m_slot + 1) % 32;
    m_drop = v && m_pend && (m_slot != 0);
    if (m_slot == 0) begin
      m_frame = {enc_word(m_hr), enc_word(m_hl)};
      m_pend = 0;
    end
    if (v) begin
      m_hl = l;
      m_hr = r;
      m_pend = 1;
    end
  endtask

  task automatic model_reset();
    m_slot = -1;
    m_frame = 32'd0;
    m_hl = 16'd0;
    m_hr = 16'd0;
    m_pend = 0;
    m_drop = 0;
  endtask

  task automatic tick(input logic en, input logic v,
                      input logic [15:0] l, input logic [15:0] r);
    clk_en = en;
    sample_valid = v;
    left = l;
    right = r;
    @(posedge clk);
    if (en && rst_n) model_step(v, l, r);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 16'h0, 16'h0);
  endtask

  // Advance until the next enabled tick drives slot s.
  task automatic run_to(input int s);
    int guard;
    guard = 0;
    while (((m_slot + 1) % 32) != s && guard < 64) begin
      tick(1'b1, 1'b0, 16'h0, 16'h0);
      guard++;
    end
    n_checks++;
    assert (guard < 64) else begin
      n_fail++;
      $error("FAIL run_to: observed timeout expected slot %0d", s);
    end
  endtask

  initial begin
    // Reset held with clk_en active: outputs stay 0.
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 16'h0, 16'h0);
    #2 rst_n = 1'b1;

    // Zero-pair frames.
    idle(70);

    // Mid-frame capture of 0x0100 / 0x0400.
    run_to(8);
    tick(1'b1, 1'b1, 16'h0100, 16'h0400);
    idle(60);

    // Full-scale values.
    run_to(20);
    tick(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    idle(60);

    // Two captures in one frame: drop at B, B sent, then repeated.
    run_to(5);
    tick(1'b1, 1'b1, 16'h1234, 16'hFEDC);
    idle(6);
    tick(1'b1, 1'b1, 16'hC000, 16'h0003);
    idle(70);

    // B pending, C captured on the load tick.
    run_to(10);
    tick(1'b1, 1'b1, 16'h2A5F, 16'hF001);
    run_to(0);
    tick(1'b1, 1'b1, 16'hFFFF, 16'h03FF);
    idle(70);

    // Randomized traffic with clk_en gaps.
    for (int k = 0; k < 600; k++) begin
      logic en, v;
      logic [15:0] l, r;
      en = ($urandom_range(3) != 0);
      v  = ($urandom_range(9) == 0);
      l  = 16'($urandom);
      r  = 16'($urandom);
      if ($urandom_range(3) == 0) l = 16'(l >>> $urandom_range(15));
      if ($urandom_range(3) == 0) r = 16'($signed(r) >>> $urandom_range(15));
      tick(en, v, l, r);
    end

    // Reset at slot 20 with a pending pair, then gapped restart.
    run_to(18);
    tick(1'b1, 1'b1, 16'h5555, 16'hAAAA);
    idle(1);
    tick(1'b0, 1'b0, 16'h0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int k = 0; k < 2; k++) tick(1'b1, 1'b1, 16'h7777, 16'h7777);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick(($urandom_range(2) == 0), 1'b0, 16'h0, 16'h0);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jt51_so_tx.md
Name: jt51_so_tx

Overview:
- Serial DAC transmitter for the JT51 output path.
- Takes the exact 16-bit left/right samples produced by the accumulator, once per sample period.
- Converts each sample to the floating format: 10-bit two's-complement mantissa plus 3-bit exponent.
- Shifts both channels out on a single data line with two sample-hold strobes, in the YM3012-style stream the external DAC decoder consumes.

Parameters:
- none (frame geometry is fixed: 32 slots per frame, left word then right word)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- clk_en  input  1  bit-slot enable; all state advances only on cycles with clk_en=1
- sample_valid  input  1  new sample pair present on left/right; qualified by clk_en
- left  input  16  signed linear left sample
- right  input  16  signed linear right sample
- so  output  1  serial data, LSB-first within each field
- sh1  output  1  left sample-hold strobe
- sh2  output  1  right sample-hold strobe
- frame_start  output  1  high for the slot-0 period of each frame
- drop  output  1  one-clk_en-period pulse: a pending, untransmitted pair was overwritten

Behaviour:
- Asynchronous reset (rst_n=0), effective immediately regardless of clk_en:
  - slot counter = 0; holding registers = 0; pending = 0; shift register = 0.
  - so = 0, sh1 = 0, sh2 = 0, frame_start = 0, drop = 0.
- Slot counter:
  - 5 bits; increments on every clk_en and wraps 31→0.
  - Slots 0-15 carry the left word; slots 16-31 carry the right word.
- Word layout (16 slots):
  - slots 0-2: 0.
  - slots 3-12: mantissa bits 0..9.
  - slots 13-15: exponent bits 0..2.
- Encoding (combinational from the holding registers at load time):
  - e = the smallest value in 0..6 such that lin>>>e is representable in signed 10 bits.
  - man = lin[9+e:e]; exp = e+1, range 1..7. exp=0 is never emitted.
- Capture: on clk_en with sample_valid=1, left/right are written into the holding registers and pending is set.
  - If pending was already 1, drop pulses for that clk_en period.
- Load: on the clk_en where the counter wraps 31→0, the 32-bit shift register is loaded with the encoded left word then the right word, and pending clears.
  - No new sample since the last load: the holding contents are re-sent unchanged (repeat, no flag).
  - sample_valid on the same clk_en as a load: the load uses the old holding contents. The new pair is captured, pending stays 1, and the pair goes out in the next frame; no drop.
- Outputs are registered and updated on clk_en. The value for slot k is held from the clk_en at which the counter becomes k until the next clk_en.
  - so = shift register bit for slot k.
  - sh1 = 1 in slots 13-15; sh2 = 1 in slots 29-31; both 0 otherwise.
  - frame_start = 1 in slot 0.
- Latency: a pair captured at slot s appears starting at slot 0 of the next frame. It is fully shifted out 32 clk_en later.
- Reset mid-frame aborts the frame. After release, slot 0 is driven on the first clk_en, with an all-zero load (man=0, exp=1).
- With clk_en=0 indefinitely, all outputs and state hold.

Test Plan:
- Reset then clk_en every cycle with no samples:
  - so carries the zero-pair pattern: only slot 13 = 1 and slot 29 = 1 (exp=1).
  - sh1 high in slots 13-15, sh2 high in slots 29-31; frame_start every 32 enables.
- left=16'h0100, right=16'h0400 captured mid-frame:
  - Next frame: left man=0x100, exp=1; right man=0x100, exp=3.
  - Bits check LSB-first at slots 3-15 and 19-31.
- left=16'h7FFF, right=16'h8000:
  - left man=0x1FF, exp=7; right man=0x200, exp=7.
  - Verify sign bit at slot 12 / 28.
- Two sample_valid pulses within one frame (A then B):
  - drop pulses once at B; next frame sends B.
  - Following frame repeats B when no new sample arrives.
- sample_valid on the counter-31 clk_en with pair C while pair B is pending:
  - The frame starting now sends B; the following frame sends C; drop stays 0.
- rst_n asserted at slot 20 with clk_en gaps:
  - Outputs go to 0 immediately without a clk edge.
  - After release, counter restarts at 0; gapped clk_en only stretches slots.
